sync_fifo_ctrl: RTL

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_ptr_ctrl.sv | 77 +++++++
 rtl/sync_fifo_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO controller: pointer width and
// the default almost-full threshold.
package fifo_pkg;

    localparam int DEFAULT_DEPTH_LOG = 8;

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    function automatic int ptr_w(input int depth_log);
        return depth_log + 1;
    endfunction

    function automatic int af_default(input int depth_log);
        return (2 ** depth_log) - 2;
    endfunction

    localparam int DEFAULT_AF_LEVEL = af_default(DEFAULT_DEPTH_LOG);

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and status-flag engine for sync_fifo_ctrl. Accept strobes
// are combinational; pointers, count and flags update on the clock edge.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter  int DEPTH_LOG = DEFAULT_DEPTH_LOG,
    parameter  int AF_LEVEL  = af_default(DEPTH_LOG),
    localparam int PW        = ptr_w(DEPTH_LOG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 write_req,
    input  logic                 read_req,
    output logic                 push_ok,
    output logic                 pop_ok,
    output logic [DEPTH_LOG-1:0] wr_addr,
    output logic [DEPTH_LOG-1:0] rd_addr,
    output logic [PW-1:0]        count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full
);

    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;

    // Nothing is accepted during a reset cycle, so no RAM write can slip through.
    assign push_ok = rst_n && write_req && !full_q;
    assign pop_ok  = rst_n && read_req && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + PW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - PW'(1);
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                  (wr_ptr_d[PW-2:0] == rd_ptr_d[PW-2:0]);
        af_d    = (count_d >= AF_THRESH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
        end
    end

    assign wr_addr     = wr_ptr_q[DEPTH_LOG-1:0];
    assign rd_addr     = rd_ptr_q[DEPTH_LOG-1:0];
    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = af_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller driving an external RAM (combinational read).
// Define SYNC_FIFO_CTRL_ERR_FLAG_EN to add sticky overflow/underflow outputs.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = DEFAULT_DEPTH_LOG,
    parameter int AF_LEVEL  = af_default(DEPTH_LOG)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        write_req,
    input  logic [WIDTH-1:0]            write_data,
    input  logic                        read_req,
    output logic [WIDTH-1:0]            read_data,
    output logic                        read_valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic [ptr_w(DEPTH_LOG)-1:0] count,
    output logic                        ram_write_req,
    output logic [DEPTH_LOG-1:0]        ram_write_addr,
    output logic [WIDTH-1:0]            ram_write_data,
    output logic [DEPTH_LOG-1:0]        ram_read_addr,
`ifdef SYNC_FIFO_CTRL_ERR_FLAG_EN
    output logic                        overflow,
    output logic                        underflow,
`endif
    input  logic [WIDTH-1:0]            ram_read_data
);

    logic             push_ok;
    logic             pop_ok;
    logic [WIDTH-1:0] read_data_q, read_data_d;
    logic             read_valid_q, read_valid_d;

    fifo_ptr_ctrl #(
        .DEPTH_LOG (DEPTH_LOG),
        .AF_LEVEL  (AF_LEVEL)
    ) u_ptr_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .write_req   (write_req),
        .read_req    (read_req),
        .push_ok     (push_ok),
        .pop_ok      (pop_ok),
        .wr_addr     (ram_write_addr),
        .rd_addr     (ram_read_addr),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
    );

    assign ram_write_req  = push_ok;
    assign ram_write_data = write_data;

    // read_data holds the last popped word between pops.
    always_comb begin
        read_data_d  = read_data_q;
        read_valid_d = pop_ok;
        if (pop_ok) begin
            read_data_d = ram_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;

`ifdef SYNC_FIFO_CTRL_ERR_FLAG_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  || (write_req && full);
        underflow_d = underflow_q || (read_req && empty);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
